buffer_reader: RTL and testbench
================================

BUFFER_READER -- requirements
Module: buffer_reader

Interface
REQ-001 Parameters SHALL be: ADDRESS_DEPTH, default 512, words per bank; BANK_COUNT, default 3, banks read in parallel; BANDWIDTH, default 128, data bits per bank; READ_LATENCY, default 2, cycles from read issue to valid dout_flat; FIFO_DEPTH, default READ_LATENCY+2, output FIFO entries.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle request to begin a burst; sampled only in IDLE.
REQ-006 start_addr  input  clog2(ADDRESS_DEPTH)  first word address, sampled with start.
REQ-007 word_count  input  clog2(ADDRESS_DEPTH)+1  words in the burst, 0..ADDRESS_DEPTH, sampled with start.
REQ-008 ceb  output  1  buffer read enable, one word read per high cycle.
REQ-009 adb_flat  output  clog2(ADDRESS_DEPTH)*BANK_COUNT  read address, same value replicated into every bank slice.
REQ-010 dout_flat  input  BANDWIDTH*BANK_COUNT  buffer read data, valid READ_LATENCY cycles after its ceb cycle.
REQ-011 m_data  output  BANDWIDTH*BANK_COUNT  output word, FIFO head.
REQ-012 m_valid  output  1  m_data is valid.
REQ-013 m_ready  input  1  consumer accepts m_data when m_valid is also high.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse when the last word of a burst is accepted.

Function
REQ-016 States SHALL be IDLE, READ and DRAIN.
- IDLE->READ: start=1 and word_count>0.
- READ->DRAIN: last read issued.
- DRAIN->IDLE: last word accepted.
REQ-017 start with word_count=0 in IDLE SHALL stay in IDLE, issue no reads, and pulse done in the following cycle.
REQ-018 start while busy=1 SHALL be ignored.
REQ-019 In READ, ceb SHALL be 1 in a cycle only if outstanding reads plus FIFO occupancy is less than FIFO_DEPTH; otherwise ceb SHALL be 0.
REQ-020 Read addresses SHALL be start_addr, start_addr+1, ..., incrementing modulo ADDRESS_DEPTH, so address ADDRESS_DEPTH-1 is followed by 0.
REQ-021 The block SHALL track outstanding reads with a READ_LATENCY-deep valid shift register; dout_flat SHALL be written into the FIFO in the cycle its valid bit emerges.
REQ-022 The FIFO SHALL never overflow, and words SHALL leave in address order with no loss or duplication under any m_ready pattern.
REQ-023 The FIFO SHALL support push and pop in the same cycle, including when it is full.
REQ-024 m_valid SHALL equal FIFO non-empty. m_data SHALL be stable while m_valid=1 and m_ready=0.
REQ-025 Latency: with start at cycle 0 and m_ready=1, the first ceb SHALL be at cycle 1 and the first m_valid at cycle READ_LATENCY+2.
REQ-026 Throughput: with m_ready held at 1, the block SHALL sustain one word per cycle.
REQ-027 done SHALL pulse in the cycle after the handshake that accepts the last word; busy SHALL fall in that same cycle.

Reset
REQ-028 While reset_n=0, the block SHALL force: state=IDLE; ceb=0; adb_flat=0; m_valid=0; m_data=0; busy=0; done=0; FIFO empty; pipeline valid bits cleared.
REQ-029 Reset asserted mid-burst SHALL discard all in-flight and buffered words; after release, no stale word SHALL appear on m_data.

Verification
REQ-030 Defaults; start, start_addr=10, word_count=4, m_ready=1 -> ceb high cycles 1-4 with addresses 10-13; m_valid cycles 4-7 carrying the data for 10-13; done at cycle 8.
REQ-031 start_addr=510, word_count=4 -> addresses 510, 511, 0, 1 in that order.
REQ-032 word_count=8, m_ready=0 for 20 cycles then 1 -> at most FIFO_DEPTH=4 reads issued before release; then all 8 words delivered in order with none lost.
REQ-033 word_count=0 -> no ceb; done one cycle after start; busy never high.
REQ-034 Random m_ready toggling over a 512-word burst -> output sequence equals the buffer contents at addresses 0-511; exactly one done pulse.
REQ-035 reset_n low at cycle 3 of an 8-word burst -> all outputs take their reset values immediately; a new burst after release returns only new-burst data.

Source files
------------

// File: rtl/buffer_reader_if.sv
// buffer_reader_if: burst control, buffer read port and output stream of buffer_reader.
interface buffer_reader_if #(
  parameter int ADDRESS_DEPTH = 512,
  parameter int BANK_COUNT    = 3,
  parameter int BANDWIDTH     = 128
);
  localparam int AW = $clog2(ADDRESS_DEPTH);
  localparam int DW = BANDWIDTH * BANK_COUNT;
  logic                     start;
  logic [AW-1:0]            start_addr;
  logic [AW:0]              word_count;
  logic                     ceb;
  logic [AW*BANK_COUNT-1:0] adb_flat;
  logic [DW-1:0]            dout_flat;
  logic [DW-1:0]            m_data;
  logic                     m_valid;
  logic                     m_ready;
  logic                     busy;
  logic                     done;
  modport master (
    input  start, start_addr, word_count, dout_flat, m_ready,
    output ceb, adb_flat, m_data, m_valid, busy, done
  );
  modport slave (
    output start, start_addr, word_count, dout_flat, m_ready,
    input  ceb, adb_flat, m_data, m_valid, busy, done
  );
endinterface

// File: rtl/buffer_reader.sv
// buffer_reader: reads a burst of consecutive multi-bank buffer words and streams them out
// through a small FIFO; reads are only issued when the FIFO can absorb every in-flight word.
module buffer_reader #(
  parameter int ADDRESS_DEPTH = 512,
  parameter int BANK_COUNT    = 3,
  parameter int BANDWIDTH     = 128,
  parameter int READ_LATENCY  = 2,
  parameter int FIFO_DEPTH    = READ_LATENCY + 2
) (
  input logic             clk,
  input logic             reset_n,
  buffer_reader_if.master bus
);
  localparam int AW = $clog2(ADDRESS_DEPTH);
  localparam int DW = BANDWIDTH * BANK_COUNT;
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int SW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t                  r_state, w_state_n;
  logic [AW-1:0]           r_addr;
  logic [AW:0]             r_to_issue, r_to_accept;
  logic [READ_LATENCY-1:0] r_vld;
  logic [DW-1:0]           r_mem [FIFO_DEPTH];
  logic [PW-1:0]           r_wr, r_rd;
  logic [SW-1:0]           r_count, w_inflight;
  logic                    r_done;
  logic                    w_start, w_ceb, w_push, w_pop, w_last_acc, w_valid;
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) w_inflight = w_inflight + SW'(r_vld[i]);
  end
  assign w_start    = r_state == IDLE && bus.start;
  // credit check: every read in flight must already have a FIFO slot reserved
  assign w_ceb      = r_state == READ && r_to_issue != '0 && (w_inflight + r_count) < SW'(FIFO_DEPTH);
  assign w_push     = r_vld[READ_LATENCY-1];
  assign w_valid    = r_count != '0;
  assign w_pop      = w_valid && bus.m_ready;
  assign w_last_acc = w_pop && r_to_accept == (AW+1)'(1);
  always_comb begin
    w_state_n = (w_start && bus.word_count != '0) ? READ :
                (r_state == READ && w_ceb && r_to_issue == (AW+1)'(1)) ? DRAIN :
                (r_state == DRAIN && w_last_acc) ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_to_issue  <= '0;
      r_to_accept <= '0;
      r_vld       <= '0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_count     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_vld   <= READ_LATENCY'({r_vld, w_ceb});
      r_done  <= (w_start && bus.word_count == '0) || w_last_acc;
      if (w_start) begin
        r_addr      <= bus.start_addr;
        r_to_issue  <= bus.word_count;
        r_to_accept <= bus.word_count;
      end else begin
        if (w_ceb) begin
          r_addr     <= r_addr == AW'(ADDRESS_DEPTH - 1) ? '0 : r_addr + AW'(1);
          r_to_issue <= r_to_issue - (AW+1)'(1);
        end
        if (w_pop) r_to_accept <= r_to_accept - (AW+1)'(1);
      end
      if (w_push) r_wr <= r_wr == PW'(FIFO_DEPTH - 1) ? '0 : r_wr + PW'(1);
      if (w_pop) r_rd <= r_rd == PW'(FIFO_DEPTH - 1) ? '0 : r_rd + PW'(1);
      r_count <= r_count + SW'(w_push) - SW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= bus.dout_flat;
  end
  assign bus.ceb      = w_ceb;
  assign bus.adb_flat = {BANK_COUNT{r_addr}};
  assign bus.m_valid  = w_valid;
  assign bus.m_data   = w_valid ? r_mem[r_rd] : '0;
  assign bus.busy     = r_state != IDLE;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_buffer_reader.sv
// tb_buffer_reader: vector table, random bursts and a mid-burst reset, checked against a
// buffer memory model and the expected address/data sequence of each burst.
module tb_buffer_reader;
  localparam int AD = 512, BC = 3, BW = 128, RL = 2, FD = RL + 2;
  localparam int AW = $clog2(AD), DW = BW * BC;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  buffer_reader_if #(.ADDRESS_DEPTH(AD), .BANK_COUNT(BC), .BANDWIDTH(BW)) bus ();
  buffer_reader #(.ADDRESS_DEPTH(AD), .BANK_COUNT(BC), .BANDWIDTH(BW), .READ_LATENCY(RL), .FIFO_DEPTH(FD))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  logic [DW-1:0] mem [AD];
  logic [DW-1:0] pipe [RL];
  always @(posedge clk) begin
    pipe[0] <= bus.ceb ? mem[bus.adb_flat[AW-1:0]] : ~mem[0];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.dout_flat = pipe[RL-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int q_addr[$], q_acyc[$], q_vcyc[$], q_done[$];
  logic [DW-1:0] q_out[$];
  int n_busy = 0, n_stab_err = 0, n_slice_err = 0;
  bit p_hold = 1'b0;
  logic [DW-1:0] p_data;
  always @(negedge clk) begin
    if (!reset_n) p_hold = 1'b0;
    else begin
      if (bus.ceb) begin
        q_addr.push_back(int'(bus.adb_flat[AW-1:0]));
        q_acyc.push_back(cyc);
        if (bus.adb_flat != {BC{bus.adb_flat[AW-1:0]}}) n_slice_err++;
      end
      if (bus.m_valid) q_vcyc.push_back(cyc);
      if (bus.m_valid && bus.m_ready) q_out.push_back(bus.m_data);
      if (bus.done) q_done.push_back(cyc);
      if (bus.busy) n_busy++;
      if (p_hold && (!bus.m_valid || bus.m_data != p_data)) n_stab_err++;
      p_hold = bus.m_valid && !bus.m_ready;
      p_data = bus.m_data;
    end
  end

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int hold, input int k);
    return mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : (k >= hold);
  endfunction

  task automatic run_burst(input int sa, input int wc, input int mode, input int hold, input int poke,
                           input int e_ceb, input int e_val, input int e_done);
    int ba, bo, bv, bd, bb, bs, bl, t0, k, bad, n;
    ba = q_addr.size(); bo = q_out.size(); bv = q_vcyc.size(); bd = q_done.size();
    bb = n_busy; bs = n_stab_err; bl = n_slice_err;
    @(posedge clk); #1;
    t0 = cyc;
    bus.start = 1'b1; bus.start_addr = AW'(sa); bus.word_count = (AW+1)'(wc);
    bus.m_ready = rdy(mode, hold, 0);
    k = 0;
    while (q_done.size() == bd && k < 4000) begin
      @(posedge clk); #1;
      k++;
      bus.start = poke != 0 && k == 2;
      if (k == 2) begin bus.start_addr = AW'(sa + 77); bus.word_count = (AW+1)'(3); end
      bus.m_ready = rdy(mode, hold, k);
    end
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; bus.start = 1'b0; bus.m_ready = 1'b1; end
    chk("burst_timeout", k < 4000, 1);
    chk("read_count", q_addr.size() - ba, wc);
    bad = 0;
    for (int i = ba; i < q_addr.size(); i++) if (q_addr[i] != (sa + i - ba) % AD) bad++;
    chk("read_addr_order", bad, 0);
    chk("word_count_out", q_out.size() - bo, wc);
    bad = 0;
    for (int i = bo; i < q_out.size(); i++) if (q_out[i] != mem[(sa + i - bo) % AD]) bad++;
    chk("data_order", bad, 0);
    chk("done_pulses", q_done.size() - bd, 1);
    chk("m_data_stable", n_stab_err - bs, 0);
    chk("adb_slices", n_slice_err - bl, 0);
    if (e_ceb >= 0) chk("first_ceb_cycle", q_acyc.size() > ba ? q_acyc[ba] - t0 : -1, e_ceb);
    if (e_val >= 0) chk("first_valid_cycle", q_vcyc.size() > bv ? q_vcyc[bv] - t0 : -1, e_val);
    if (e_done >= 0) chk("done_cycle", q_done.size() > bd ? q_done[bd] - t0 : -1, e_done);
    if (wc == 0) chk("busy_cycles", n_busy - bb, 0);
    if (mode == 2) begin
      n = 0;
      for (int i = ba; i < q_acyc.size(); i++) if (q_acyc[i] - t0 < hold) n++;
      chk("reads_before_release", n, FD);
    end
  endtask

  typedef struct { int sa; int wc; int mode; int hold; int poke; int e_ceb; int e_val; int e_done; } vec_t;
  vec_t v[$];

  initial begin
    int bo, bd;
    v.push_back('{10, 4, 0, 0, 0, 1, 4, 8});
    v.push_back('{510, 4, 0, 0, 0, 1, 4, 8});
    v.push_back('{300, 0, 0, 0, 0, -1, -1, 1});
    v.push_back('{100, 1, 0, 0, 0, 1, 4, 5});
    v.push_back('{511, 2, 0, 0, 0, 1, 4, 6});
    v.push_back('{7, 8, 2, 20, 0, 1, 4, 28});
    v.push_back('{0, 512, 1, 0, 1, 1, -1, -1});
    v.push_back('{450, 100, 0, 0, 1, 1, 4, 104});
    for (int a = 0; a < AD; a++)
      for (int j = 0; j < DW / 32; j++) mem[a][j*32 +: 32] = $urandom;
    bus.start = 1'b0; bus.start_addr = '0; bus.word_count = '0; bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ceb", bus.ceb, 0);
    chk("rst_adb", bus.adb_flat == '0, 1);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data == '0, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    foreach (v[i]) run_burst(v[i].sa, v[i].wc, v[i].mode, v[i].hold, v[i].poke, v[i].e_ceb, v[i].e_val, v[i].e_done);
    for (int r = 0; r < 6; r++)
      run_burst(int'($urandom_range(0, AD - 1)), int'($urandom_range(1, 60)), 1, 0, 1, 1, -1, -1);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.start_addr = AW'(50); bus.word_count = (AW+1)'(8); bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_busy", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ceb", bus.ceb, 0);
    chk("mid_rst_adb", bus.adb_flat == '0, 1);
    chk("mid_rst_m_valid", bus.m_valid, 0);
    chk("mid_rst_m_data", bus.m_data == '0, 1);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    bo = q_out.size(); bd = q_done.size();
    repeat (6) @(posedge clk);
    #1;
    chk("stale_words_after_reset", q_out.size() - bo, 0);
    chk("stale_done_after_reset", q_done.size() - bd, 0);
    chk("idle_after_reset", {bus.m_valid, bus.busy}, 0);
    run_burst(200, 3, 0, 0, 0, 1, 4, 7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
